// File: rtl/inverse_substitution_box_generator_pkg.sv
// -----------------------------------------------------------------------------
// inverse_substitution_box_generator_pkg
// Shared definitions for the forward and inverse S-box generators: table
// geometry (row width, row count, entry count, byte width) and the encoding
// of the generator control states.
// -----------------------------------------------------------------------------
package inverse_substitution_box_generator_pkg;

    localparam int KEY_SIZE      = 128;
    localparam int NUM_ROWS      = 16;
    localparam int NUM_ENTRIES   = 256;
    localparam int BYTE_W        = 8;
    localparam int BYTES_PER_ROW = KEY_SIZE / BYTE_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        INVERT  = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage : inverse_substitution_box_generator_pkg

// File: rtl/inverse_substitution_box_generator_table.sv
// -----------------------------------------------------------------------------
// sbox_byte_table
// 256 x 8 register array holding one S-box.
//   clk, rst        : clock, asynchronous active-high clear of every entry
//   clr_i           : synchronous clear of every entry
//   load_i          : bulk load of all entries from load_rows_i
//   load_rows_i     : 16 x 128 row image (column 0 in the MSB byte)
//   we_i/addr_i/data_i : single-entry write port
//   rd_addr_i/rd_data_o: combinational single-entry read port
//   rows_o          : 16 x 128 row view of the registered entries
// Priority when several controls are active: clr_i, load_i, we_i.
// -----------------------------------------------------------------------------
module sbox_byte_table
    import inverse_substitution_box_generator_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clr_i,
    input  logic                               load_i,
    input  logic [NUM_ROWS-1:0][KEY_SIZE-1:0]  load_rows_i,
    input  logic                               we_i,
    input  logic [BYTE_W-1:0]                  addr_i,
    input  logic [BYTE_W-1:0]                  data_i,
    input  logic [BYTE_W-1:0]                  rd_addr_i,
    output logic [BYTE_W-1:0]                  rd_data_o,
    output logic [NUM_ROWS-1:0][KEY_SIZE-1:0]  rows_o
);

    logic [BYTE_W-1:0] mem_q [NUM_ENTRIES];

    // Entry storage: clear, bulk load or single write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (load_i) begin
            // entry i lives in row i/16, byte column i%16 counted from the MSB
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mem_q[i] <= load_rows_i[i / BYTES_PER_ROW]
                                       [KEY_SIZE - 1 - BYTE_W * (i % BYTES_PER_ROW) -: BYTE_W];
            end
        end else if (we_i) begin
            mem_q[addr_i] <= data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        for (genvar c = 0; c < BYTES_PER_ROW; c++) begin : g_col
            assign rows_o[r][KEY_SIZE - 1 - BYTE_W * c -: BYTE_W] = mem_q[r * BYTES_PER_ROW + c];
        end
    end

endmodule : sbox_byte_table

// File: rtl/inverse_substitution_box_generator.sv
// -----------------------------------------------------------------------------
// inverse_substitution_box_generator
// Builds the inverse of a 256-entry forward S-box, one entry per cycle, and
// flags a forward table that is not a permutation.
//   clk            : clock, rising edge
//   reset          : asynchronous active-high reset
//   enable_bar     : active-low run enable; high stalls the inversion
//   sbox_ready     : forward table valid
//   sbox_row_0..15 : forward table rows (column 0 in the MSB byte)
//   inv_sbox_row_0..15 : inverse table rows, same layout, registered
//   ready          : inverse complete and stable (registered)
//   error          : a duplicate forward value was seen (registered, sticky)
// -----------------------------------------------------------------------------
module inverse_substitution_box_generator
    import inverse_substitution_box_generator_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_bar,
    input  logic                sbox_ready,
    input  logic [KEY_SIZE-1:0] sbox_row_0,
    input  logic [KEY_SIZE-1:0] sbox_row_1,
    input  logic [KEY_SIZE-1:0] sbox_row_2,
    input  logic [KEY_SIZE-1:0] sbox_row_3,
    input  logic [KEY_SIZE-1:0] sbox_row_4,
    input  logic [KEY_SIZE-1:0] sbox_row_5,
    input  logic [KEY_SIZE-1:0] sbox_row_6,
    input  logic [KEY_SIZE-1:0] sbox_row_7,
    input  logic [KEY_SIZE-1:0] sbox_row_8,
    input  logic [KEY_SIZE-1:0] sbox_row_9,
    input  logic [KEY_SIZE-1:0] sbox_row_10,
    input  logic [KEY_SIZE-1:0] sbox_row_11,
    input  logic [KEY_SIZE-1:0] sbox_row_12,
    input  logic [KEY_SIZE-1:0] sbox_row_13,
    input  logic [KEY_SIZE-1:0] sbox_row_14,
    input  logic [KEY_SIZE-1:0] sbox_row_15,
    output logic [KEY_SIZE-1:0] inv_sbox_row_0,
    output logic [KEY_SIZE-1:0] inv_sbox_row_1,
    output logic [KEY_SIZE-1:0] inv_sbox_row_2,
    output logic [KEY_SIZE-1:0] inv_sbox_row_3,
    output logic [KEY_SIZE-1:0] inv_sbox_row_4,
    output logic [KEY_SIZE-1:0] inv_sbox_row_5,
    output logic [KEY_SIZE-1:0] inv_sbox_row_6,
    output logic [KEY_SIZE-1:0] inv_sbox_row_7,
    output logic [KEY_SIZE-1:0] inv_sbox_row_8,
    output logic [KEY_SIZE-1:0] inv_sbox_row_9,
    output logic [KEY_SIZE-1:0] inv_sbox_row_10,
    output logic [KEY_SIZE-1:0] inv_sbox_row_11,
    output logic [KEY_SIZE-1:0] inv_sbox_row_12,
    output logic [KEY_SIZE-1:0] inv_sbox_row_13,
    output logic [KEY_SIZE-1:0] inv_sbox_row_14,
    output logic [KEY_SIZE-1:0] inv_sbox_row_15,
    output logic                ready,
    output logic                error
);

    logic [NUM_ROWS-1:0][KEY_SIZE-1:0] fwd_in_rows_s;
    logic [NUM_ROWS-1:0][KEY_SIZE-1:0] fwd_copy_rows_s;
    logic [NUM_ROWS-1:0][KEY_SIZE-1:0] inv_rows_s;

    state_t                 state_q, state_d;
    logic [BYTE_W-1:0]      index_q, index_d;
    logic [NUM_ENTRIES-1:0] seen_q, seen_d;
    logic                   error_q, error_d;
    logic                   ready_q, ready_d;

    logic                   capture_s;
    logic                   inv_we_s;
    logic [BYTE_W-1:0]      fwd_val_s;
    logic [BYTE_W-1:0]      inv_rd_s;

    assign fwd_in_rows_s[0]  = sbox_row_0;
    assign fwd_in_rows_s[1]  = sbox_row_1;
    assign fwd_in_rows_s[2]  = sbox_row_2;
    assign fwd_in_rows_s[3]  = sbox_row_3;
    assign fwd_in_rows_s[4]  = sbox_row_4;
    assign fwd_in_rows_s[5]  = sbox_row_5;
    assign fwd_in_rows_s[6]  = sbox_row_6;
    assign fwd_in_rows_s[7]  = sbox_row_7;
    assign fwd_in_rows_s[8]  = sbox_row_8;
    assign fwd_in_rows_s[9]  = sbox_row_9;
    assign fwd_in_rows_s[10] = sbox_row_10;
    assign fwd_in_rows_s[11] = sbox_row_11;
    assign fwd_in_rows_s[12] = sbox_row_12;
    assign fwd_in_rows_s[13] = sbox_row_13;
    assign fwd_in_rows_s[14] = sbox_row_14;
    assign fwd_in_rows_s[15] = sbox_row_15;

    // Private copy of the forward table so input changes after capture are ignored.
    sbox_byte_table u_fwd_table (
        .clk         (clk),
        .rst         (reset),
        .clr_i       (1'b0),
        .load_i      (capture_s),
        .load_rows_i (fwd_in_rows_s),
        .we_i        (1'b0),
        .addr_i      (8'h00),
        .data_i      (8'h00),
        .rd_addr_i   (index_q),
        .rd_data_o   (fwd_val_s),
        .rows_o      (fwd_copy_rows_s)
    );

    // Inverse table: cleared at capture, written inv[fwd[index]] = index.
    sbox_byte_table u_inv_table (
        .clk         (clk),
        .rst         (reset),
        .clr_i       (capture_s),
        .load_i      (1'b0),
        .load_rows_i ('0),
        .we_i        (inv_we_s),
        .addr_i      (fwd_val_s),
        .data_i      (index_q),
        .rd_addr_i   (8'h00),
        .rd_data_o   (inv_rd_s),
        .rows_o      (inv_rows_s)
    );

    // Next-state, counter, bitmap and flag logic of the inversion sequencer.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        seen_d    = seen_q;
        error_d   = error_q;
        ready_d   = ready_q;
        capture_s = 1'b0;
        inv_we_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sbox_ready && !enable_bar) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                capture_s = 1'b1;
                seen_d    = '0;
                error_d   = 1'b0;
                ready_d   = 1'b0;
                index_d   = 8'd0;
                state_d   = INVERT;
            end
            INVERT: begin
                if (!enable_bar) begin
                    // first writer wins; any later hit on the same value is a duplicate
                    if (!seen_q[fwd_val_s]) begin
                        inv_we_s          = 1'b1;
                        seen_d[fwd_val_s] = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    if (index_q == 8'd255) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                    end else begin
                        index_d = index_q + 8'd1;
                    end
                end else begin
                    state_d = INVERT;
                end
            end
            DONE: begin
                if (!sbox_ready) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                end else begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            index_q <= 8'd0;
            seen_q  <= '0;
            error_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            seen_q  <= seen_d;
            error_q <= error_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
    assign error = error_q;

    assign inv_sbox_row_0  = inv_rows_s[0];
    assign inv_sbox_row_1  = inv_rows_s[1];
    assign inv_sbox_row_2  = inv_rows_s[2];
    assign inv_sbox_row_3  = inv_rows_s[3];
    assign inv_sbox_row_4  = inv_rows_s[4];
    assign inv_sbox_row_5  = inv_rows_s[5];
    assign inv_sbox_row_6  = inv_rows_s[6];
    assign inv_sbox_row_7  = inv_rows_s[7];
    assign inv_sbox_row_8  = inv_rows_s[8];
    assign inv_sbox_row_9  = inv_rows_s[9];
    assign inv_sbox_row_10 = inv_rows_s[10];
    assign inv_sbox_row_11 = inv_rows_s[11];
    assign inv_sbox_row_12 = inv_rows_s[12];
    assign inv_sbox_row_13 = inv_rows_s[13];
    assign inv_sbox_row_14 = inv_rows_s[14];
    assign inv_sbox_row_15 = inv_rows_s[15];

endmodule : inverse_substitution_box_generator

// File: tb/tb_inverse_substitution_box_generator.sv
// -----------------------------------------------------------------------------
// tb_inverse_substitution_box_generator
// Random and directed forward tables checked against a first-writer inverse
// model; latency, stalls, duplicate detection and asynchronous reset covered.
// -----------------------------------------------------------------------------
module tb_inverse_substitution_box_generator;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable_bar;
    logic         sbox_ready;
    logic [127:0] row_in  [16];
    logic [127:0] row_out [16];
    logic         ready;
    logic         error;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] fwd_m [256];
    logic [7:0] inv_m [256];
    logic       err_m;
    int         dup_m;

    always #5 clk = ~clk;

    inverse_substitution_box_generator dut (
        .clk(clk), .reset(reset), .enable_bar(enable_bar), .sbox_ready(sbox_ready),
        .sbox_row_0(row_in[0]),   .sbox_row_1(row_in[1]),   .sbox_row_2(row_in[2]),   .sbox_row_3(row_in[3]),
        .sbox_row_4(row_in[4]),   .sbox_row_5(row_in[5]),   .sbox_row_6(row_in[6]),   .sbox_row_7(row_in[7]),
        .sbox_row_8(row_in[8]),   .sbox_row_9(row_in[9]),   .sbox_row_10(row_in[10]), .sbox_row_11(row_in[11]),
        .sbox_row_12(row_in[12]), .sbox_row_13(row_in[13]), .sbox_row_14(row_in[14]), .sbox_row_15(row_in[15]),
        .inv_sbox_row_0(row_out[0]),   .inv_sbox_row_1(row_out[1]),   .inv_sbox_row_2(row_out[2]),
        .inv_sbox_row_3(row_out[3]),   .inv_sbox_row_4(row_out[4]),   .inv_sbox_row_5(row_out[5]),
        .inv_sbox_row_6(row_out[6]),   .inv_sbox_row_7(row_out[7]),   .inv_sbox_row_8(row_out[8]),
        .inv_sbox_row_9(row_out[9]),   .inv_sbox_row_10(row_out[10]), .inv_sbox_row_11(row_out[11]),
        .inv_sbox_row_12(row_out[12]), .inv_sbox_row_13(row_out[13]), .inv_sbox_row_14(row_out[14]),
        .inv_sbox_row_15(row_out[15]),
        .ready(ready), .error(error)
    );

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // AES S-box from its definition: GF(2^8) inverse then affine map.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] b = 8'h00;
        logic [7:0] kk;
        for (int k = 1; k < 256; k++) begin
            kk = k[7:0];
            if (gmul(x, kk) == 8'h01) b = kk;
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Reference inverse: first occurrence of each value defines inv[value].
    task automatic build_model();
        bit seen [256];
        err_m = 1'b0;
        dup_m = -1;
        for (int v = 0; v < 256; v++) begin
            inv_m[v] = 8'h00;
            seen[v]  = 1'b0;
        end
        for (int i = 0; i < 256; i++) begin
            if (!seen[fwd_m[i]]) begin
                seen[fwd_m[i]]  = 1'b1;
                inv_m[fwd_m[i]] = 8'(i);
            end else begin
                if (dup_m < 0) dup_m = i;
                err_m = 1'b1;
            end
        end
    endtask

    function automatic logic [127:0] model_row(input int r);
        logic [127:0] e = '0;
        for (int c = 0; c < 16; c++) e[127 - 8 * c -: 8] = inv_m[16 * r + c];
        return e;
    endfunction

    task automatic drive_rows();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                row_in[r][127 - 8 * c -: 8] = fwd_m[16 * r + c];
    endtask

    task automatic random_perm();
        logic [7:0] t;
        int j;
        for (int i = 0; i < 256; i++) fwd_m[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = fwd_m[i]; fwd_m[i] = fwd_m[j]; fwd_m[j] = t;
        end
    endtask

    task automatic check_rows(input string name);
        for (int r = 0; r < 16; r++)
            check_value($sformatf("%s row%0d", name, r), row_out[r], model_row(r));
    endtask

    // One full run: raise sbox_ready, optionally stall, check latency and result.
    task automatic run_table(input string name, input int stall_at, input int stall_len);
        int cycles = 0;
        bit done = 1'b0;
        build_model();
        drive_rows();
        enable_bar = 1'b0;
        sbox_ready = 1'b1;
        while (!done && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
            if (stall_len > 0 && cycles == stall_at + 2)             enable_bar = 1'b1;
            if (stall_len > 0 && cycles == stall_at + 2 + stall_len) enable_bar = 1'b0;
            if (cycles == 5)
                for (int r = 0; r < 16; r++) row_in[r] = {$urandom, $urandom, $urandom, $urandom};
            if (stall_len == 0 && dup_m >= 0 && cycles == dup_m + 2)
                check_value({name, " err before dup"}, 128'(error), 128'(1'b0));
            if (stall_len == 0 && dup_m >= 0 && cycles == dup_m + 3)
                check_value({name, " err at dup"}, 128'(error), 128'(1'b1));
            if (ready) done = 1'b1;
        end
        check_value({name, " latency"}, 128'(cycles), 128'(258 + stall_len));
        check_value({name, " error"}, 128'(error), 128'(err_m));
        check_rows(name);
        sbox_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_value({name, " ready drop"}, 128'(ready), 128'(1'b0));
        check_value({name, " err kept"}, 128'(error), 128'(err_m));
        check_value({name, " row5 kept"}, row_out[5], model_row(5));
    endtask

    initial begin
        logic [7:0] saved [256];
        reset      = 1'b1;
        enable_bar = 1'b0;
        sbox_ready = 1'b0;
        for (int r = 0; r < 16; r++) row_in[r] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_value("reset ready", 128'(ready), 128'(1'b0));
        check_value("reset error", 128'(error), 128'(1'b0));
        for (int r = 0; r < 16; r++) check_value($sformatf("reset row%0d", r), row_out[r], '0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 256; i++) fwd_m[i] = 8'(i);
        run_table("identity", 0, 0);
        check_value("identity row0 const", row_out[0], 128'h000102030405060708090A0B0C0D0E0F);
        check_value("identity row15 const", row_out[15], 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);

        for (int i = 0; i < 256; i++) fwd_m[i] = aes_sbox(8'(i));
        run_table("aes", 0, 0);
        check_value("aes row0 const", row_out[0], 128'h52096AD53036A538BF40A39E81F3D7FB);
        check_value("aes inv63", 128'(row_out[6][127 - 8 * 3 -: 8]), 128'(8'h00));
        check_value("aes inv7c", 128'(row_out[7][127 - 8 * 12 -: 8]), 128'(8'h01));

        for (int i = 0; i < 256; i++) fwd_m[i] = 8'h00;
        run_table("allzero", 0, 0);

        random_perm();
        for (int i = 0; i < 256; i++) saved[i] = fwd_m[i];
        run_table("perm nostall", 0, 0);
        for (int i = 0; i < 256; i++) fwd_m[i] = saved[i];
        run_table("perm stall100", 100, 10);

        for (int t = 0; t < 4; t++) begin
            random_perm();
            run_table($sformatf("rperm%0d", t), $urandom_range(250, 0), $urandom_range(6, 1));
        end

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 256; i++) fwd_m[i] = 8'($urandom);
            run_table($sformatf("rbytes%0d", t), 0, 0);
        end

        // Asynchronous reset in the middle of an inversion.
        random_perm();
        drive_rows();
        sbox_ready = 1'b1;
        enable_bar = 1'b0;
        repeat (102) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_value("midreset ready", 128'(ready), 128'(1'b0));
        check_value("midreset error", 128'(error), 128'(1'b0));
        for (int r = 0; r < 16; r++) check_value($sformatf("midreset row%0d", r), row_out[r], '0);
        sbox_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        random_perm();
        run_table("after reset", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_inverse_substitution_box_generator
